// File: rtl/accum_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : accum_alu_seq
// Purpose  : Accumulator ALU; single-cycle logic/arith ops, bit-serial shifts.
// Revision : 1.0 - initial release
// ============================================================================
module accum_alu_seq #(
    parameter int DATALEN  = 8,
    parameter int MODELEN  = 4,
    parameter int ERRORLEN = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MODELEN-1:0]  mode,
    input  logic [DATALEN-1:0]  inA,
    input  logic [DATALEN-1:0]  inB,
    input  logic                clear,
    output logic [DATALEN-1:0]  out,
    output logic [ERRORLEN-1:0] error,
    output logic                busy,
    output logic                done
);

    localparam int SHAMT_W = (DATALEN > 1) ? $clog2(DATALEN) : 1;

    localparam logic [MODELEN-1:0] c_OP_NOP = MODELEN'(4'b0000);
    localparam logic [MODELEN-1:0] c_OP_NOT = MODELEN'(4'b0001);
    localparam logic [MODELEN-1:0] c_OP_SHL = MODELEN'(4'b0010);
    localparam logic [MODELEN-1:0] c_OP_SHR = MODELEN'(4'b0011);
    localparam logic [MODELEN-1:0] c_OP_LD  = MODELEN'(4'b0100);
    localparam logic [MODELEN-1:0] c_OP_AND = MODELEN'(4'b0101);
    localparam logic [MODELEN-1:0] c_OP_OR  = MODELEN'(4'b0110);
    localparam logic [MODELEN-1:0] c_OP_XOR = MODELEN'(4'b0111);
    localparam logic [MODELEN-1:0] c_OP_ADD = MODELEN'(4'b1000);
    localparam logic [MODELEN-1:0] c_OP_SUB = MODELEN'(4'b1001);

    localparam logic [ERRORLEN-1:0] c_ERR_NONE  = ERRORLEN'(2'b00);
    localparam logic [ERRORLEN-1:0] c_ERR_OVF   = ERRORLEN'(2'b01);
    localparam logic [ERRORLEN-1:0] c_ERR_UNF   = ERRORLEN'(2'b10);
    localparam logic [ERRORLEN-1:0] c_ERR_ILLEG = ERRORLEN'(2'b11);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                state_q;
    logic [SHAMT_W-1:0]    cnt_q;
    logic                  dir_right_q;
    logic [DATALEN-1:0]    out_q;
    logic [ERRORLEN-1:0]   err_q;
    logic                  done_q;

    logic [DATALEN:0]      w_sum;
    logic [DATALEN-1:0]    w_diff;
    logic                  w_borrow;
    logic [SHAMT_W-1:0]    w_amt;
    logic [DATALEN-1:0]    w_shl;
    logic [DATALEN-1:0]    w_shr;

    assign w_sum    = {1'b0, inA} + {1'b0, inB};
    assign w_diff   = inA - inB;
    assign w_borrow = (inA < inB);
    assign w_amt    = inB[SHAMT_W-1:0];
    assign w_shl    = {out_q[DATALEN-2:0], 1'b0};
    assign w_shr    = {1'b0, out_q[DATALEN-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dir_right_q <= 1'b0;
            out_q       <= '0;
            err_q       <= c_ERR_NONE;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                out_q   <= '0;
                err_q   <= c_ERR_NONE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            done_q <= 1'b1;
                            case (mode)
                                c_OP_NOP: err_q <= c_ERR_NONE;
                                c_OP_NOT: begin
                                    out_q <= ~inA;
                                    err_q <= c_ERR_NONE;
                                end
                                c_OP_LD: begin
                                    out_q <= inA;
                                    err_q <= c_ERR_NONE;
                                end
                                c_OP_AND: begin
                                    out_q <= inA & inB;
                                    err_q <= c_ERR_NONE;
                                end
                                c_OP_OR: begin
                                    out_q <= inA | inB;
                                    err_q <= c_ERR_NONE;
                                end
                                c_OP_XOR: begin
                                    out_q <= inA ^ inB;
                                    err_q <= c_ERR_NONE;
                                end
                                c_OP_ADD: begin
                                    out_q <= w_sum[DATALEN-1:0];
                                    err_q <= w_sum[DATALEN] ? c_ERR_OVF : c_ERR_NONE;
                                end
                                c_OP_SUB: begin
                                    out_q <= w_diff;
                                    err_q <= w_borrow ? c_ERR_UNF : c_ERR_NONE;
                                end
                                c_OP_SHL, c_OP_SHR: begin
                                    // Operand is loaded now; the shifting happens one bit per edge in S_SHIFT.
                                    out_q       <= inA;
                                    err_q       <= c_ERR_NONE;
                                    cnt_q       <= w_amt;
                                    dir_right_q <= (mode == c_OP_SHR);
                                    if (w_amt != '0) begin
                                        state_q <= S_SHIFT;
                                        done_q  <= 1'b0;
                                    end
                                end
                                default: err_q <= c_ERR_ILLEG;
                            endcase
                        end
                    end
                    S_SHIFT: begin
                        // Error is sticky for the rest of the shift once any set bit falls off.
                        if (dir_right_q) begin
                            out_q <= w_shr;
                            if (out_q[0]) err_q <= c_ERR_UNF;
                        end else begin
                            out_q <= w_shl;
                            if (out_q[DATALEN-1]) err_q <= c_ERR_OVF;
                        end
                        cnt_q <= cnt_q - SHAMT_W'(1);
                        if (cnt_q == SHAMT_W'(1)) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign out   = out_q;
    assign error = err_q;
    assign busy  = (state_q == S_SHIFT);
    assign done  = done_q;

endmodule
`default_nettype wire
